// File: rtl/regram_pkg.sv
// regram_pkg: shared state type and round-robin search helper for regram_wr_sched
package regram_pkg;
  typedef enum logic {INIT, RUN} regram_sched_state_e;
  localparam int RR_MAX = 32;
  function automatic int rr_first(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
    int idx;
    rr_first = -1;
    // walk the search order backwards so the earliest hit in order wins
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (valid[idx[4:0]]) rr_first = idx;
    end
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, first valid requester at or above the pointer
module rr_arbiter import regram_pkg::*; #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);
  int w_idx;
  assign w_idx = rr_first(RR_MAX'(valid), int'(ptr), NREQ);
  assign grant = (w_idx < 0) ? '0 : NREQ'(1) << w_idx;
endmodule

// File: rtl/sync_regram.sv
// sync_regram: register memory with one clocked write port and one combinational read port
module sync_regram #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 64,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  always_ff @(posedge clk) if (we_i) r_mem[waddr_i] <= wdata_i;
  assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/regram_wr_sched.sv
// regram_wr_sched: init sweep plus round-robin write sharing for sync_regram
// REGRAM_WR_BYPASS_EN adds same-cycle write-to-read forwarding in RUN.
module regram_wr_sched import regram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 64,
  parameter int NREQ = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int AW = $clog2(DATA_DEPTH),
  localparam int PW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            wvalid_i,
  input  logic [NREQ*AW-1:0]         waddr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NREQ-1:0]            wready_o,
  input  logic [AW-1:0]              raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       init_done_o
);
  regram_sched_state_e r_state;
  logic [AW-1:0] r_cnt;
  logic [PW-1:0] r_ptr;
  logic w_run, w_we, w_any;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0] w_gidx;
  logic [AW-1:0] w_gaddr, w_waddr;
  logic [DATA_WIDTH-1:0] w_gdata, w_wdata, w_mem;
  assign w_run = r_state == RUN;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.valid(w_run ? wvalid_i : '0), .ptr(r_ptr), .grant(w_grant));
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) if (w_grant[i]) w_gidx = PW'(i);
  end
  assign w_any = |w_grant;
  assign w_gaddr = waddr_i[int'(w_gidx)*AW +: AW];
  assign w_gdata = wdata_i[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
  // a reset edge must not commit a user write
  assign w_we = rst_n && (!w_run || w_any);
  assign w_waddr = w_run ? w_gaddr : r_cnt;
  assign w_wdata = w_run ? w_gdata : INIT_VALUE;
  sync_regram #(.DATA_WIDTH(DATA_WIDTH), .DATA_DEPTH(DATA_DEPTH)) u_mem (
    .clk(clk), .we_i(w_we), .waddr_i(w_waddr), .wdata_i(w_wdata),
    .raddr_i(raddr_i), .rdata_o(w_mem)
  );
  assign wready_o = w_grant;
  assign init_done_o = w_run;
`ifdef REGRAM_WR_BYPASS_EN
  assign rdata_o = !w_run ? '0 : (w_any && w_gaddr == raddr_i) ? w_gdata : w_mem;
`else
  assign rdata_o = w_run ? w_mem : '0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_ptr <= '0;
    end else if (!w_run) begin
      r_cnt <= r_cnt + 1'b1;
      if (int'(r_cnt) == DATA_DEPTH - 1) r_state <= RUN;
    end else if (w_any) begin
      r_ptr <= (int'(w_gidx) == NREQ - 1) ? '0 : w_gidx + 1'b1;
    end
  end
endmodule

// File: tb/tb_regram_wr_sched.sv
// tb_regram_wr_sched: random and directed checks against a behavioural table model
module tb_regram_wr_sched;
  localparam int DW = 32, DD = 64, NR = 2, AW = 6;
  localparam logic [DW-1:0] IV = 32'hDEAD_BEEF;
  logic clk = 0, rst_n = 0;
  logic [NR-1:0] wvalid = '0;
  logic [AW-1:0] wa [NR];
  logic [DW-1:0] wd [NR];
  logic [AW-1:0] raddr = '0;
  logic [NR-1:0] wready;
  logic [DW-1:0] rdata;
  logic done;
  int vectors = 0, errs = 0;
  logic [DW-1:0] mem [DD];
  int init_left = DD, ptr = 0;
  bit model_ok = 0;
  always #5 clk = ~clk;
  regram_wr_sched #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .NREQ(NR), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n), .wvalid_i(wvalid), .waddr_i({wa[1], wa[0]}),
    .wdata_i({wd[1], wd[0]}), .wready_o(wready), .raddr_i(raddr), .rdata_o(rdata),
    .init_done_o(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int exp_g();
    if (init_left > 0) return -1;
    for (int k = 0; k < NR; k++) if (wvalid[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction
  task automatic check_model();
    int g;
    logic [DW-1:0] er;
    if (!model_ok) return;
    g = exp_g();
    er = (init_left > 0) ? '0 : mem[raddr];
`ifdef REGRAM_WR_BYPASS_EN
    if (g >= 0 && wa[g] == raddr) er = wd[g];
`endif
    chk("model_wready", wready, (g < 0) ? 0 : (1 << g));
    chk("model_init_done", done, (init_left == 0) ? 1 : 0);
    chk("model_rdata", rdata, er);
  endtask
  task automatic model_edge();
    int g;
    if (!rst_n) begin
      init_left = DD;
      ptr = 0;
      model_ok = 1;
    end else if (model_ok && init_left > 0) begin
      mem[DD - init_left] = IV;
      init_left--;
    end else if (model_ok) begin
      g = exp_g();
      if (g >= 0) begin
        mem[wa[g]] = wd[g];
        ptr = (g + 1) % NR;
      end
    end
  endtask
  task automatic cyc();
    #2;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    int rd [3];
    rd = '{0, 31, 63};
    for (int i = 0; i < NR; i++) begin
      wa[i] = AW'($urandom);
      wd[i] = $urandom;
    end
    repeat (2) cyc();
    rst_n = 1;
    wvalid = 2'b11;
    for (int i = 0; i < DD; i++) begin
      #1 chk("init_wready", wready, 0);
      cyc();
    end
    wvalid = '0;
    #1 chk("init_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      raddr = AW'(rd[i]);
      #1 chk("init_read", rdata, IV);
      cyc();
    end
    wa[0] = 5; wa[1] = 9; wvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wd[0] = 32'(k / 2 + 1);
      wd[1] = 32'(k / 2 + 11);
      #1 chk("alt_grant", wready, (k % 2) ? 2 : 1);
      cyc();
    end
    wvalid = '0; raddr = 5;
    #1 chk("alt_read5", rdata, 3);
    cyc();
    raddr = 9;
    #1 chk("alt_read9", rdata, 13);
    cyc();
    wvalid = 2'b01; wa[0] = 20;
    cyc();
    wvalid = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'hA; wd[1] = 32'hB;
    #1 chk("same_first", wready, 2);
    cyc();
    wvalid = 2'b01;
    #1 chk("same_second", wready, 1);
    cyc();
    wvalid = '0; raddr = 7;
    #1 chk("same_read", rdata, 32'hA);
    cyc();
    wvalid = 2'b01; wa[0] = 3; wd[0] = 0;
    cyc();
    wd[0] = 32'h55; raddr = 3;
`ifdef REGRAM_WR_BYPASS_EN
    #1 chk("bypass_same", rdata, 32'h55);
`else
    #1 chk("bypass_same", rdata, 0);
`endif
    cyc();
    wvalid = '0;
    #1 chk("bypass_next", rdata, 32'h55);
    cyc();
    wvalid = 2'b10;
    cyc();
    #1 chk("wrap_grant", wready, 2);
    cyc();
    wvalid = 2'b01;
    #1 chk("wrap_next", wready, 1);
    cyc();
    wa[0] = 2; wd[0] = 32'h77; rst_n = 0;
    cyc();
    rst_n = 1;
    #1 chk("rst_done", done, 0);
    chk("rst_wready", wready, 0);
    repeat (DD) cyc();
    wvalid = '0; raddr = 2;
    #1 chk("rst_read", rdata, IV);
    cyc();
    for (int n = 0; n < 500; n++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      wvalid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        wa[i] = AW'($urandom_range(0, 15));
        wd[i] = $urandom;
      end
      raddr = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, NR - 1)] : AW'($urandom_range(0, 15));
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
